// File: rtl/seq_divider.sv
// Radix-2 restoring sequential divider: one quotient bit per clock, optional
// two's-complement mode, divide-by-zero short-cut and Busy/Done handshake.
module seq_divider #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Done,
    output logic             Busy,
    output logic             DivZero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             qneg_q, rneg_q;
    logic             done_q, busy_q, dz_q;

    logic             sgn_mode;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted, trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_d, dvd_d;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        sgn_mode = SIGNED_EN && Signed;
        a_abs    = (sgn_mode && A[WIDTH-1]) ? -A : A;
        b_abs    = (sgn_mode && B[WIDTH-1]) ? -B : B;
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        // A set top bit already exceeds any divisor; otherwise trial's top bit is the borrow.
        borrow   = ~shifted[WIDTH] & trial[WIDTH];
        rem_d    = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d    = {dvd_q[WIDTH-2:0], ~borrow};
        q_fix    = qneg_q ? -dvd_q : dvd_q;
        r_fix    = rneg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Load) begin
                        if (B == '0) begin
                            q_q    <= '1;
                            r_q    <= A;
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            dvd_q   <= a_abs;
                            dvs_q   <= b_abs;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            qneg_q  <= sgn_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
                            rneg_q  <= sgn_mode && A[WIDTH-1];
                            busy_q  <= 1'b1;
                            state_q <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    q_q     <= q_fix;
                    r_q     <= r_fix;
                    dz_q    <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Q       = q_q;
    assign R       = r_q;
    assign Done    = done_q;
    assign Busy    = busy_q;
    assign DivZero = dz_q;

endmodule
